int_ctrl_nested: RTL
====================

Name: int_ctrl_nested

Overview:
Parametrised, nesting-capable interrupt controller that sits between peripheral interrupt lines and the CPU control unit. It latches requests per channel in level or edge mode and applies a per-channel mask. It arbitrates by fixed priority (channel 0 highest), tracks in-service channels for nested preemption, and supplies the handler vector address. It also retires the active handler on return.

Parameters:
N_IRQ, 8, number of interrupt channels (2..32)
ADDR_W, 10, width of vector address
VEC_BASE, 10'h200, vector of channel 0; channel k vector = VEC_BASE + k

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
irq_in  in  N_IRQ  raw interrupt lines, already synchronous to clk
int_en  in  1  global enable; gates int_req only
int_ack  in  1  CPU takes the current request (one-cycle pulse, "call")
int_ret  in  1  CPU returns from current handler (one-cycle pulse)
cfg_we  in  1  configuration write strobe
cfg_sel  in  1  0 = mask register, 1 = edge-mode register
cfg_wdata  in  N_IRQ  configuration write data
int_req  out  1  eligible request present
int_vec  out  ADDR_W  vector of winning channel
s_interr  out  1  at least one channel in service
pend  out  N_IRQ  pending register
insvc  out  N_IRQ  in-service register

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset (at next rising edge with reset=1):
  - pend=0, insvc=0, mask=all ones (enabled), edge=0 (all level).
  - Outputs: int_req=0, int_vec=0, s_interr=0.
  - irq_prev samples irq_in during reset. No spurious edge after release.
  - Reset mid-handler discards all pending and in-service state.
- Request capture, per channel k, every cycle:
  - Level mode: set_k = irq_in[k].
  - Edge mode: set_k = irq_in[k] & ~irq_prev[k] (rising edge only).
  - irq_prev <= irq_in every cycle.
- Pending update: pend[k] <= set_k | (pend[k] & ~clr_k), where clr_k = ack accepted for channel k.
  - Set wins over clear in the same cycle; no request is lost.
- Mask:
  - Masking does not clear pend; it only removes the channel from arbitration.
  - A cfg write takes effect the cycle after cfg_we.
- Arbitration (combinational from registers):
  - hp = lowest index set in insvc. If insvc=0, all channels are allowed.
  - allowed = channels with index < hp.
  - elig = pend & mask & allowed.
  - int_req = int_en & |elig.
  - win = lowest index set in elig.
  - int_vec = VEC_BASE + win when int_req=1, else 0.
- Latency: irq_in high at edge t gives pend at t+1, and int_req in the same cycle as pend.
- Ack:
  - Accepted only when int_ack & int_req.
  - Effect at next edge: insvc[win] <= 1, pend[win] <= 0 (subject to set-wins).
  - int_ack with int_req=0 is ignored.
- Return:
  - int_ret clears the lowest-index set bit of insvc.
  - Ignored when insvc=0.
- Simultaneous int_ack and int_ret:
  - Both apply. Ret clears the current hp bit; ack sets the win bit, which was computed before the update.
- Nesting:
  - A higher-priority request preempts an in-service lower-priority one.
  - An equal or lower priority request waits until the return.
  - Maximum nesting depth is N_IRQ.
- s_interr = |insvc.
- Level-mode source held high after return re-pends. Deasserting the source is the handler's responsibility.

Test Plan:
1. Reset with irq_in=8'hFF held -> after release pend=8'hFF (level), int_req=int_en; with int_en=0, int_req=0 and int_vec=0.
2. Level ch3: irq_in=8'h08 one cycle, int_en=1 -> next cycle pend=8'h08, int_req=1, int_vec=10'h203; int_ack -> insvc=8'h08, pend=0, s_interr=1, int_req=0.
3. Nesting: ch3 in service; raise ch5 -> int_req=0. Raise ch1 -> int_vec=10'h201; ack -> insvc=8'h0A. First ret -> insvc=8'h08 and ch5 still blocked. Second ret -> insvc=0, int_vec=10'h205.
4. Edge ch2 (cfg_sel=1, cfg_wdata=8'h04): irq_in[2] high 6 cycles -> exactly one pend set. Ack -> pend stays 0 while the line stays high. Low then high -> pends again.
5. Mask ch4 (cfg_sel=0, cfg_wdata=8'hEF): irq_in[4] pulse -> pend=8'h10, int_req=0. Write 8'hFF -> next cycle int_req=1, int_vec=10'h204.
6. Corner cases:
   - Ack of ch3 while the ch3 level line is still high -> insvc[3]=1 and pend[3] stays 1, but the request is blocked.
   - int_ack and int_ret same cycle with insvc=8'h08 and ch0 pending -> insvc=8'h01.

Source files
------------

// File: rtl/int_ctrl_nested.sv
// int_ctrl_nested: nesting-capable interrupt controller between peripheral
// interrupt lines and the CPU control unit.
//
// Each channel latches a request in level or edge mode into a pending register.
// A per-channel mask removes a channel from arbitration without clearing its
// pending bit. Arbitration is fixed priority, with channel 0 highest. Only
// channels of strictly higher priority than the highest in-service channel may
// be presented to the CPU, which is what allows nested preemption.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   irq_in     raw interrupt lines, already synchronous to clk
//   int_en     global enable; gates int_req only
//   int_ack    CPU accepts the presented request (one-cycle pulse)
//   int_ret    CPU returns from the current handler (one-cycle pulse)
//   cfg_we     configuration write strobe
//   cfg_sel    0 = mask register, 1 = edge-mode register
//   cfg_wdata  configuration write data
//   int_req    an eligible request is present
//   int_vec    handler vector of the winning channel (0 when int_req=0)
//   s_interr   at least one channel is in service
//   pend       pending register
//   insvc      in-service register
module int_ctrl_nested #(
  parameter int unsigned         N_IRQ    = 8,
  parameter int unsigned         ADDR_W   = 10,
  parameter logic [ADDR_W-1:0]   VEC_BASE = 10'h200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic              int_en,
  input  logic              int_ack,
  input  logic              int_ret,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [N_IRQ-1:0]  cfg_wdata,
  output logic              int_req,
  output logic [ADDR_W-1:0] int_vec,
  output logic              s_interr,
  output logic [N_IRQ-1:0]  pend,
  output logic [N_IRQ-1:0]  insvc
);

  localparam int unsigned IdxW = $clog2(N_IRQ);
  localparam logic [N_IRQ-1:0] One = N_IRQ'(1);

  // Isolate the lowest set bit. The result is zero when v is zero.
  function automatic logic [N_IRQ-1:0] lowest_oh(input logic [N_IRQ-1:0] v);
    return v & (~v + One);
  endfunction

  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] insvc_q, insvc_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] edge_q, edge_d;
  logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;

  logic [N_IRQ-1:0] set_vec;
  logic [N_IRQ-1:0] hp_oh;
  logic [N_IRQ-1:0] allowed;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] win_oh;
  logic [IdxW-1:0]  win_idx;
  logic             ack_acc;
  logic [N_IRQ-1:0] clr_vec;
  logic [N_IRQ-1:0] ret_clr;

  // Request capture. Level channels follow the line. Edge channels fire only
  // on a 0->1 transition relative to the previous cycle's sample.
  always_comb begin
    set_vec = irq_in & (~edge_q | ~irq_prev_q);
  end

  // Arbitration, computed purely from registered state.
  always_comb begin
    hp_oh = lowest_oh(insvc_q);
    // Channels strictly below the highest-priority in-service index. With
    // nothing in service, hp_oh is 0 and the subtraction wraps to all ones.
    allowed = hp_oh - One;
    elig    = pend_q & mask_q & allowed;
    win_oh  = lowest_oh(elig);

    win_idx = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (elig[k]) begin
        win_idx = IdxW'(k);
      end
    end

    int_req  = int_en & (|elig);
    int_vec  = int_req ? (VEC_BASE + ADDR_W'(win_idx)) : '0;
    s_interr = |insvc_q;
    pend     = pend_q;
    insvc    = insvc_q;
  end

  // Next-state logic for pending, in-service and configuration registers.
  always_comb begin
    ack_acc = int_ack & int_req;
    clr_vec = ack_acc ? win_oh : '0;
    // Return retires the highest-priority in-service channel. It is a no-op
    // when insvc is empty because hp_oh is zero.
    ret_clr = int_ret ? hp_oh : '0;

    // A new set in the same cycle as an ack clear keeps the bit pending.
    pend_d     = set_vec | (pend_q & ~clr_vec);
    // The ack uses the winner computed before this update, so a simultaneous
    // return and ack compose independently.
    insvc_d    = (insvc_q & ~ret_clr) | clr_vec;
    irq_prev_d = irq_in;

    mask_d = mask_q;
    edge_d = edge_q;
    if (cfg_we) begin
      if (cfg_sel) begin
        edge_d = cfg_wdata;
      end else begin
        mask_d = cfg_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= '0;
      insvc_q    <= '0;
      mask_q     <= '1;
      edge_q     <= '0;
      // Track the lines during reset so an edge channel does not see a
      // spurious edge on release.
      irq_prev_q <= irq_in;
    end else begin
      pend_q     <= pend_d;
      insvc_q    <= insvc_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      irq_prev_q <= irq_prev_d;
    end
  end

endmodule
